// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

  // Default geometry and thresholds of the standard FIFO instance.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_AF_THRESH  = 28;
  localparam int DEF_AE_THRESH  = 4;

  // Read-mode selectors for the FWFT parameter.
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2, used to size pointers from DEPTH.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the write word; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, thresholds, sticky errors, flush and FWFT option.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WIDTH      = clog2(DEPTH),
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [WIDTH:0]        count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [WIDTH:0]   CNT_FULL = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0]   CNT_AF   = (WIDTH+1)'(AF_THRESH);
  localparam logic [WIDTH:0]   CNT_AE   = (WIDTH+1)'(AE_THRESH);
  localparam logic [WIDTH:0]   CNT_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] PTR_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH:0]        count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  wrOk, rdOk;

  // Acceptance is judged against the registered flags from before the edge.
  assign wrOk = wen & ~full_q;
  assign rdOk = ren & ~empty_q;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (wrOk & ~clear),
    .waddr_i(wptr_q),
    .wdata_i(data_in),
    .raddr_i(rptr_q),
    .rdata_o(memRdata)
  );

  // Next-state pointers, count, sticky errors and output word; flags follow the new count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dout_d  = dout_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      dout_d  = '0;
    end else begin
      ovf_d = ovf_q | (wen & full_q);
      unf_d = unf_q | (ren & empty_q);
      if (wrOk) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rdOk) begin
        rptr_d = rptr_q + PTR_ONE;
        dout_d = memRdata;
      end
      case ({wrOk, rdOk})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_AF);
    aempty_d = (count_d <= CNT_AE);
  end

  // State register; reset empties the FIFO immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // In FWFT mode the head word is shown directly; zero is driven while empty.
  assign data_out     = (FWFT == MODE_FWFT) ? (empty_q ? '0 : memRdata) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: a standard-mode and an FWFT instance share stimulus and a queue model.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int DEP = DEF_DEPTH;
  localparam int CW  = clog2(DEP) + 1;
  localparam int AFT = DEF_AF_THRESH;
  localparam int AET = DEF_AE_THRESH;

  logic          clk = 1'b0;
  logic          rst, clear, wen, ren;
  logic [DW-1:0] data_in;

  logic [DW-1:0] doutStd, doutFwft;
  logic          fullStd, emptyStd, afStd, aeStd, ovfStd, unfStd;
  logic          fullFwft, emptyFwft, afFwft, aeFwft, ovfFwft, unfFwft;
  logic [CW-1:0] countStd, countFwft;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain queue of stored words plus sticky error bits.
  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] expRead[$];
  bit            modelOvf, modelUnf;
  logic [DW-1:0] stdDout;

  // Free-running clock.
  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .WIDTH(CW-1),
    .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(MODE_STD)
  ) dutStd (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(doutStd), .full(fullStd), .empty(emptyStd), .almost_full(afStd),
    .almost_empty(aeStd), .count(countStd), .overflow(ovfStd), .underflow(unfStd)
  );

  sync_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .WIDTH(CW-1),
    .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(MODE_FWFT)
  ) dutFwft (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(doutFwft), .full(fullFwft), .empty(emptyFwft), .almost_full(afFwft),
    .almost_empty(aeFwft), .count(countFwft), .overflow(ovfFwft), .underflow(unfFwft)
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW+5:0] expFlags();
    int n;
    n = modelQ.size();
    return {CW'(n), (n == DEP), (n == 0), (n >= AFT), (n <= AET), modelOvf, modelUnf};
  endfunction

  function automatic logic [CW+5:0] stdFlags();
    return {countStd, fullStd, emptyStd, afStd, aeStd, ovfStd, unfStd};
  endfunction

  function automatic logic [CW+5:0] fwftFlags();
    return {countFwft, fullFwft, emptyFwft, afFwft, aeFwft, ovfFwft, unfFwft};
  endfunction

  task automatic modelStep(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int n;
    n = modelQ.size();
    if (c) begin
      modelQ.delete();
      modelOvf = 0;
      modelUnf = 0;
      stdDout  = '0;
    end else begin
      if (w && n == DEP) modelOvf = 1;
      if (r && n == 0)   modelUnf = 1;
      if (r && n > 0) begin
        stdDout = modelQ.pop_front();
        expRead.push_back(stdDout);
      end
      if (w && n < DEP) modelQ.push_back(d);
    end
  endtask

  task automatic checkOutput();
    compare("flags_std", 32'(stdFlags()), 32'(expFlags()));
    compare("flags_fwft", 32'(fwftFlags()), 32'(expFlags()));
    compare("dout_std_hold", 32'(doutStd), 32'(stdDout));
    if (modelQ.size() > 0) compare("head_fwft", 32'(doutFwft), 32'(modelQ[0]));
  endtask

  task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    @(negedge clk);
    wen     = w;
    data_in = d;
    ren     = r;
    clear   = c;
    @(posedge clk);
    modelStep(w, d, r, c);
    #1;
    checkOutput();
  endtask

  task automatic writeWord(input logic [DW-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic readWord();
    applyStimulus(1'b0, DW'($urandom()), 1'b1, 1'b0);
  endtask

  task automatic flush();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Reset asserted between edges must take effect before the next rising edge.
  task automatic resetMid();
    @(negedge clk);
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
    #2 rst = 1'b1;
    modelQ.delete();
    modelOvf = 0;
    modelUnf = 0;
    stdDout  = '0;
    #1;
    compare("async_rst_flags_std", 32'(stdFlags()), 32'(expFlags()));
    compare("async_rst_flags_fwft", 32'(fwftFlags()), 32'(expFlags()));
    compare("async_rst_dout_std", 32'(doutStd), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: whenever the standard instance accepts a read, the popped word must appear next.
  always @(posedge clk) begin
    if (!rst && !clear && ren && !emptyStd) begin
      #1;
      checks++;
      if (expRead.size() == 0) begin
        failures++;
        $display("[TB] FAIL read_unexpected actual=%h expected=none at %0t", doutStd, $time);
      end else begin
        logic [DW-1:0] e;
        e = expRead.pop_front();
        if (doutStd !== e) begin
          failures++;
          $display("[TB] FAIL read_data actual=%h expected=%h at %0t", doutStd, e, $time);
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    wen      = 1'b0;
    ren      = 1'b0;
    data_in  = '0;
    modelOvf = 0;
    modelUnf = 0;
    stdDout  = '0;
    repeat (2) @(negedge clk);
    compare("reset_flags_std", 32'(stdFlags()), 32'(expFlags()));
    compare("reset_flags_fwft", 32'(fwftFlags()), 32'(expFlags()));
    compare("reset_dout_std", 32'(doutStd), 32'(0));
    rst = 1'b0;

    $display("[TB] basic flow");
    for (int i = 0; i < 10; i++) writeWord(DW'(8'h11 + i));
    for (int i = 0; i < 10; i++) readWord();

    $display("[TB] fill, overflow and wrap");
    for (int i = 0; i < DEP; i++) writeWord(DW'(8'h20 + i));
    writeWord(8'hFF);
    for (int i = 0; i < 16; i++) readWord();
    for (int i = 0; i < 16; i++) writeWord(DW'(8'h60 + i));
    for (int i = 0; i < DEP; i++) readWord();
    flush();

    $display("[TB] simultaneous requests at boundaries");
    for (int i = 0; i < DEP; i++) writeWord(DW'($urandom()));
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
    flush();
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) writeWord(DW'($urandom()));
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0);
    flush();

    $display("[TB] threshold edges and FWFT head");
    writeWord(8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    writeWord(8'h3C);
    readWord();
    for (int i = 0; i < 30; i++) writeWord(DW'($urandom()));
    flush();

    $display("[TB] flush and async reset mid-stream");
    for (int i = 0; i < DEP; i++) writeWord(DW'($urandom()));
    writeWord(8'h77);
    for (int i = 0; i < 20; i++) readWord();
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) writeWord(DW'($urandom()));
    resetMid();
    for (int i = 0; i < 3; i++) writeWord(DW'($urandom()));
    for (int i = 0; i < 3; i++) readWord();

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 8; seg++) begin
      int wp, rp;
      wp = $urandom_range(15, 90);
      rp = $urandom_range(15, 90);
      for (int k = 0; k < 200; k++) begin
        applyStimulus($urandom_range(0, 99) < wp, DW'($urandom()),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 149) == 0);
      end
    end

    repeat (2) @(negedge clk);
    compare("scoreboard_drained", 32'(expRead.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 8x32 FIFO, with configurable width and depth.
- Adds a fill count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the standard buffer between same-clock producer and consumer stages.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out.
- DEPTH, 32, number of entries; power of two, at least 4.
- WIDTH, 5, pointer width, equal to log2(DEPTH).
- AF_THRESH, 28, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- wen  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- ren  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - Reset (rst) is asynchronous and active-high.
  - On rst: write pointer, read pointer and count go to 0; empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
  - Memory contents are not reset.
  - Asserting rst mid-operation discards all stored data immediately, without waiting for a clock edge.
- Write and read acceptance:
  - wr_ok = wen & ~full. On wr_ok, mem[wptr] <= data_in and wptr increments.
  - rd_ok = ren & ~empty. On rd_ok, rptr increments.
  - Both flags are evaluated against the registered state before the edge.
- Simultaneous requests:
  - wr_ok and rd_ok in the same cycle leave count unchanged, and both operations take effect.
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- Count and flags:
  - count <= count + wr_ok - rd_ok.
  - All flags are registered and derived from the next-state count. Flags are valid in the cycle after the edge that changes count, so write-to-empty-deassert latency is 1 cycle.
  - Pointers are WIDTH bits and wrap naturally from DEPTH-1 to 0. Full and empty are disambiguated by count, not by pointer comparison.
- Error flags:
  - overflow sets on wen & full; underflow sets on ren & empty.
  - Both are sticky and clear only on rst or clear.
- Standard mode (FWFT=0):
  - data_out is a register loaded with mem[rptr] on rd_ok, so data appears 1 cycle after the accepting edge.
  - data_out holds its value when no read is accepted, including on underflow.
- FWFT mode (FWFT=1):
  - data_out = mem[rptr] combinationally whenever empty=0. The head word is visible without a read, and ren acts as a pop.
  - After a pop, the next word is visible in the following cycle.
  - When empty=1, data_out is undefined.
- Flush (clear):
  - clear has priority over wen and ren in the same cycle.
  - It zeroes the pointers, count, overflow and underflow, and in standard mode zeroes data_out. Flags update as for reset on the next edge.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 function;
  - the default DATA_WIDTH, DEPTH and threshold constants;
  - localparams MODE_STD=0 and MODE_FWFT=1.
- One sub-module, fifo_mem: DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read, parametrised on DATA_WIDTH and DEPTH.
- Pointers, count, flags and output register live in sync_fifo_param.

Test Plan:
1. Reset and basic flow (defaults, FWFT=0): release rst, write 0x11..0x1A on 10 consecutive cycles, then 10 reads.
   - count reaches 10.
   - data_out gives 0x11..0x1A, each 1 cycle after its read edge.
   - empty=1 and count=0 at the end; overflow=0 and underflow=0.
2. Fill to full and wrap: write 32 words, then 1 extra write of 0xFF.
   - full=1, count=32, almost_full=1 from count 28; overflow=1 and 0xFF is dropped.
   - Read 16, write 16 more so the pointers wrap; all 32 words then read back in order.
3. Simultaneous read/write at boundaries:
   - At count=32 with wen=ren=1: read accepted, write rejected, count=31, overflow=1.
   - At count=0 with wen=ren=1: write accepted, read rejected, count=1, underflow=1.
   - At count=5 with wen=ren=1: count stays 5.
4. Threshold edges: increment count from 3 to 5.
   - almost_empty=1 at count 4 and 0 at count 5.
   - almost_full is 0 at count 27 and 1 at count 28.
5. FWFT=1: write 0xA5 into the empty FIFO.
   - The cycle after the write, empty=0 and data_out=0xA5 with no ren.
   - Write 0x3C, pulse ren once: data_out=0x3C the next cycle.
6. clear and async rst mid-stream:
   - With count=12 and overflow=1, pulse clear with wen=1: count=0, empty=1, overflow=0, write ignored.
   - Assert rst between clock edges: outputs reach their reset values before the next edge.
